// File: rtl/ifid_reg.sv
// IF/ID pipeline register: captures the fetched instruction, PC, PC+8 and delay-slot flag,
// and converts illegal fetch addresses into a nop tagged with an AdEL exception code.
module ifid_reg #(
  parameter logic [31:0] INIT     = 32'h0000_3000,
  parameter logic [31:0] IMEM_LO  = 32'h0000_3000,
  parameter logic [31:0] IMEM_HI  = 32'h0000_6FFC,
  parameter logic [4:0]  EXC_ADEL = 5'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        flush,
  input  logic [31:0] instr_F,
  input  logic [31:0] PC_F,
  input  logic        bd_F,
  output logic [31:0] instr_D,
  output logic [31:0] PC_D,
  output logic [31:0] PC8_D,
  output logic        bd_D,
  output logic [4:0]  exc_D,
  output logic        valid_D
);

  localparam logic [31:0] INIT8 = INIT + 32'd8;

  // Power-up values equal the reset/flush values so simulation starts defined.
  logic [31:0] instr_q = '0;
  logic [31:0] pc_q    = INIT;
  logic [31:0] pc8_q   = INIT8;
  logic        bd_q    = 1'b0;
  logic [4:0]  exc_q   = '0;
  logic        valid_q = 1'b0;

  logic fault;

  // Control priority is reset > flush > stall > load; stall=1 holds every D-side
  // register, flush=1 loads a bubble (valid=0) even while stalled.
  always_comb begin
    fault = (PC_F[1:0] != 2'b00) || (PC_F < IMEM_LO) || (PC_F > IMEM_HI);
  end

  always_ff @(posedge clk) begin
    if (reset || flush) begin
      instr_q <= '0;
      pc_q    <= INIT;
      pc8_q   <= INIT8;
      bd_q    <= 1'b0;
      exc_q   <= '0;
      valid_q <= 1'b0;
    end else if (!stall) begin
      // A faulting slot keeps its real PC and bd flag so EPC/BD logic sees them.
      instr_q <= fault ? 32'h0 : instr_F;
      exc_q   <= fault ? EXC_ADEL : 5'd0;
      pc_q    <= PC_F;
      pc8_q   <= PC_F + 32'd8;
      bd_q    <= bd_F;
      valid_q <= 1'b1;
    end
  end

  assign instr_D = instr_q;
  assign PC_D    = pc_q;
  assign PC8_D   = pc8_q;
  assign bd_D    = bd_q;
  assign exc_D   = exc_q;
  assign valid_D = valid_q;

endmodule

// File: tb/tb_ifid_reg.sv
// Bench for ifid_reg: directed cases plus random traffic, checked against an expected queue
// filled by a small behavioural model at drive time.
module tb_ifid_reg;

  localparam logic [31:0] INIT    = 32'h0000_3000;
  localparam logic [31:0] IMEM_LO = 32'h0000_3000;
  localparam logic [31:0] IMEM_HI = 32'h0000_6FFC;

  logic        clk = 1'b0;
  logic        reset = 1'b0, stall = 1'b0, flush = 1'b0, bd_F = 1'b0;
  logic [31:0] instr_F = '0, PC_F = INIT;
  logic [31:0] instr_D, PC_D, PC8_D;
  logic        bd_D, valid_D;
  logic [4:0]  exc_D;

  int n_cmp = 0;
  int n_bad = 0;

  // {instr, pc, pc8, bd, exc, valid}
  logic [102:0] exp_q[$];

  logic [31:0] m_instr = '0, m_pc = INIT, m_pc8 = INIT + 32'd8;
  logic        m_bd = 1'b0, m_valid = 1'b0;
  logic [4:0]  m_exc = '0;

  ifid_reg dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush),
    .instr_F(instr_F), .PC_F(PC_F), .bd_F(bd_F),
    .instr_D(instr_D), .PC_D(PC_D), .PC8_D(PC8_D),
    .bd_D(bd_D), .exc_D(exc_D), .valid_D(valid_D)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic compare_outputs(input string tag);
    logic [102:0] e;
    if (exp_q.size() == 0) begin
      check({tag, ".queue_empty"}, 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    check({tag, ".instr"}, instr_D, e[102:71]);
    check({tag, ".pc"},    PC_D,    e[70:39]);
    check({tag, ".pc8"},   PC8_D,   e[38:7]);
    check({tag, ".bd"},    {31'd0, bd_D},    {31'd0, e[6]});
    check({tag, ".exc"},   {27'd0, exc_D},   {27'd0, e[5:1]});
    check({tag, ".valid"}, {31'd0, valid_D}, {31'd0, e[0]});
  endtask

  // Drive one cycle of inputs, advance the model, then compare after the edge.
  task automatic step(input string tag, input logic rst, input logic stl, input logic fl,
                      input logic [31:0] ins, input logic [31:0] pc, input logic bd);
    logic flt;
    reset = rst; stall = stl; flush = fl; instr_F = ins; PC_F = pc; bd_F = bd;
    flt = (pc[1:0] != 2'b00) || (pc < IMEM_LO) || (pc > IMEM_HI);
    if (rst || fl) begin
      m_instr = '0; m_pc = INIT; m_pc8 = INIT + 32'd8; m_bd = 0; m_exc = '0; m_valid = 0;
    end else if (!stl) begin
      m_instr = flt ? 32'h0 : ins;
      m_exc   = flt ? 5'd4 : 5'd0;
      m_pc    = pc;
      m_pc8   = pc + 32'd8;
      m_bd    = bd;
      m_valid = 1'b1;
    end
    exp_q.push_back({m_instr, m_pc, m_pc8, m_bd, m_exc, m_valid});
    @(posedge clk);
    #1;
    compare_outputs(tag);
  endtask

  initial begin
    logic [31:0] rpc;
    #1;
    // Power-up state before any clock edge or reset.
    exp_q.push_back({32'h0, INIT, INIT + 32'd8, 1'b0, 5'd0, 1'b0});
    compare_outputs("powerup");

    step("reset",      1, 0, 0, 32'hDEAD_BEEF, 32'h3100, 1);
    step("load_3004",  0, 0, 0, 32'h2408_000A, 32'h3004, 1);
    step("load_3010",  0, 0, 0, 32'h1111_2222, 32'h3010, 0);
    for (int i = 0; i < 3; i++) step("stall_hold", 0, 1, 0, 32'h3333_4444, 32'h3014, 1);
    step("stall_release", 0, 0, 0, 32'h3333_4444, 32'h3014, 1);
    step("stall_flush",   0, 1, 1, 32'h5555_6666, 32'h3020, 1);
    step("misalign",   0, 0, 0, 32'h7777_8888, 32'h3002, 1);
    step("above_hi",   0, 0, 0, 32'h7777_8888, 32'h7000, 0);
    step("at_hi",      0, 0, 0, 32'h9999_AAAA, 32'h6FFC, 0);
    step("below_lo",   0, 0, 0, 32'h9999_AAAA, 32'h2FFC, 0);
    step("at_lo",      0, 0, 0, 32'hBBBB_CCCC, 32'h3000, 1);
    step("wrap_pc8",   0, 0, 0, 32'hBBBB_CCCC, 32'hFFFF_FFFC, 0);
    step("pre_stall",  0, 0, 0, 32'hCAFE_F00D, 32'h4000, 1);
    step("stall_a",    0, 1, 0, 32'h0BAD_0BAD, 32'h4004, 0);
    step("reset_in_stall", 1, 1, 0, 32'h0BAD_0BAD, 32'h4004, 0);
    step("stall_after_reset", 0, 1, 0, 32'h0BAD_0BAD, 32'h4008, 1);
    step("stall_after_reset2", 0, 1, 0, 32'h0BAD_0BAD, 32'h4008, 1);

    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 5))
        0:       rpc = $urandom();
        1:       rpc = IMEM_LO + $urandom_range(0, 15) - 32'd8;
        2:       rpc = IMEM_HI + $urandom_range(0, 15) - 32'd8;
        default: rpc = IMEM_LO + ($urandom_range(0, 32'h0FFF) << 2);
      endcase
      step("random", ($urandom_range(0, 31) == 0), ($urandom_range(0, 3) == 0),
           ($urandom_range(0, 9) == 0), $urandom(), rpc, 1'($urandom_range(0, 1)));
    end

    check("queue_drained", exp_q.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ifid_reg.md
Name: ifid_reg

Overview:
- Pipeline register between the fetch stage (PC register plus instruction memory) and decode in the 5-stage MIPS CPU.
- Captures the fetched instruction, its PC, PC+8 (link address) and the branch-delay-slot flag.
- Detects fetch address exceptions (AdEL) and replaces faulting instructions with a nop.
- Supports a stall (hold) and a flush (bubble insert), both driven by the hazard/exception control unit.

Parameters:
- INIT, 32'h0000_3000, PC value loaded into PC_D on reset and flush; must match the PC register's INIT.
- IMEM_LO, 32'h0000_3000, lowest legal instruction address (inclusive).
- IMEM_HI, 32'h0000_6FFC, highest legal instruction address (inclusive).
- EXC_ADEL, 5'd4, exception code emitted for an illegal fetch address.

Ports:
- clk  input  1  system clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- stall  input  1  1 = hold all D-side registers; same polarity as the PC register's stall/we input.
- flush  input  1  1 = load a bubble on the next edge.
- instr_F  input  32  instruction word from instruction memory.
- PC_F  input  32  current fetch PC, driven by the PC register output.
- bd_F  input  1  1 = instr_F sits in a branch delay slot.
- instr_D  output  32  registered instruction for decode.
- PC_D  output  32  registered PC.
- PC8_D  output  32  registered PC_F + 8.
- bd_D  output  1  registered delay-slot flag.
- exc_D  output  5  registered exception code; 0 = none.
- valid_D  output  1  1 = D stage holds a real fetched instruction; 0 = bubble.

Behaviour:
- All updates happen on posedge clk. No combinational path from inputs to outputs.
- Priority: reset > flush > stall > load.
- Reset values, also applied on flush:
  - instr_D = 0 (sll $0,$0,0, i.e. nop)
  - PC_D = INIT
  - PC8_D = INIT + 8
  - bd_D = 0
  - exc_D = 0
  - valid_D = 0
- Initial block sets the same values, so simulation starts from a defined state without a reset pulse.
- Stall (stall=1, flush=0, reset=0): every output holds its value for that cycle.
- Load (stall=0, flush=0, reset=0):
  - PC_D <= PC_F.
  - PC8_D <= PC_F + 8, computed modulo 2^32; wrap-around is allowed and not flagged.
  - bd_D <= bd_F.
  - valid_D <= 1.
- Fetch-fault check, evaluated on PC_F at load time:
  - fault = (PC_F[1:0] != 0) || (PC_F < IMEM_LO) || (PC_F > IMEM_HI). Comparisons are unsigned.
  - fault = 1: instr_D <= 0 and exc_D <= EXC_ADEL.
  - fault = 0: instr_D <= instr_F and exc_D <= 0.
  - A faulting slot still sets valid_D = 1 and captures the real PC_F and bd_F, so EPC/BD logic downstream sees the offending address.
- Latency: exactly 1 cycle from the F-side inputs to the D-side outputs when not stalled.
- stall=1 together with flush=1: the flush wins and a bubble is loaded. This is the exception-redirect case.
- Reset asserted mid-stall: reset wins and stall is ignored that cycle.
- A stall that lasts N cycles holds the outputs for exactly N edges. The first edge after stall deasserts loads the current F-side inputs.
- PC_F at the boundaries IMEM_LO and IMEM_HI is legal. IMEM_HI + 4 faults.

Test Plan:
- Reset for 1 cycle -> instr_D=0, PC_D=0x3000, PC8_D=0x3008, bd_D=0, exc_D=0, valid_D=0.
- PC_F=0x3004, instr_F=0x2408000A, bd_F=1, stall=0 -> next edge: instr_D=0x2408000A, PC_D=0x3004, PC8_D=0x300C, bd_D=1, exc_D=0, valid_D=1.
- Load 0x3010, then stall=1 for 3 cycles while PC_F changes to 0x3014 -> outputs stay at PC_D=0x3010 for all 3 edges; 4th edge (stall=0) gives PC_D=0x3014.
- stall=1, flush=1, PC_F=0x3020 -> next edge: instr_D=0, PC_D=0x3000, valid_D=0, exc_D=0.
- PC_F=0x3002 -> exc_D=4, instr_D=0, PC_D=0x3002, valid_D=1. PC_F=0x7000 -> exc_D=4. PC_F=0x6FFC -> exc_D=0. PC_F=0x2FFC -> exc_D=4.
- stall=1 held with valid data, then reset=1 for one edge -> all outputs return to reset values. After reset deasserts with stall still 1, outputs hold the reset values.
